// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one synchronous read port of a memory between two cores.  Each core
// raises a level request with an address.  Only one transaction is in flight
// at a time, and it runs through three states:
//   IDLE    -> pick a requester, latch its address onto mem_addr
//   WAIT    -> let the memory spend LATENCY cycles producing the data
//   CAPTURE -> register mem_data into the winner's rdata and pulse its ack
// When both cores request in the same IDLE cycle, the core that was not
// served last wins (round-robin).  Out of reset core 0 wins the first tie.
//
// Parameters
//   LATENCY      memory read latency in jimmy_clk cycles, legal range 1..15
//
// Ports
//   jimmy_clk    sole clock; all state changes on its rising edge
//   reset        synchronous, active-high; overrides every other update
//   req0/req1    per-core read request, held high until the matching ack
//   addr0/addr1  per-core read address, stable while the request is high
//   rdata0/1     per-core returned data, registered, held between reads
//   ack0/ack1    per-core one-cycle completion pulse
//   mem_addr     registered address to the shared memory port
//   mem_data     read data from the shared memory port
//   busy         high while a transaction is in WAIT or CAPTURE
//   grant_cnt0/1 completed-grant counters, wrap 0xFF -> 0x00
//                (only present when ARB_STATS_EN is defined)
//
// Build option
//   ARB_STATS_EN  define to add the grant_cnt0/grant_cnt1 ports and counters
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic       jimmy_clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] addr0,
  output logic [7:0] rdata0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] addr1,
  output logic [7:0] rdata1,
  output logic       ack1,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
`ifdef ARB_STATS_EN
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_CAPTURE = 2'b10
  } state_t;

  // An out-of-range LATENCY is pulled into 1..15 so the 4-bit wait counter
  // can never be loaded with a wrapped value.
  localparam int unsigned LAT_CLAMP = (LATENCY < 32'd1)  ? 32'd1  :
                                      (LATENCY > 32'd15) ? 32'd15 : LATENCY;

  // The counter is loaded with LATENCY-1 on the grant edge, so WAIT lasts
  // exactly LATENCY cycles: the edge that sees zero moves to CAPTURE.
  localparam logic [3:0] WAIT_INIT = 4'(LAT_CLAMP - 32'd1);

  state_t     state_r;
  logic [3:0] wait_cnt_r;
  logic       gnt_r;         // core being served by the transaction in flight
  logic       last_grant_r;  // core that completed most recently
  logic       any_req_s;
  logic       pick_s;

  // Round-robin choice among the cores requesting in this cycle
  always_comb begin
    any_req_s = req0 | req1;
    pick_s    = 1'b0;
    if (req0 && req1) begin
      // Tie: the core that was not served last goes next.
      pick_s = ~last_grant_r;
    end else if (req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Transaction FSM with all port-side outputs registered
  always_ff @(posedge jimmy_clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 4'd0;
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
      mem_addr     <= 8'h00;
      rdata0       <= 8'h00;
      rdata1       <= 8'h00;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only CAPTURE raises one.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            // Address is latched here and never re-read, so later changes
            // on addr0/addr1 cannot disturb the transaction in flight.
            gnt_r      <= pick_s;
            mem_addr   <= pick_s ? addr1 : addr0;
            wait_cnt_r <= WAIT_INIT;
            state_r    <= ST_WAIT;
            busy       <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_WAIT: begin
          busy <= 1'b1;
          if (wait_cnt_r == 4'd0) begin
            state_r <= ST_CAPTURE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end

        ST_CAPTURE: begin
          if (gnt_r) begin
            rdata1 <= mem_data;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= mem_data;
            ack0   <= 1'b1;
          end
          last_grant_r <= gnt_r;
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
        end

        default: begin
          // Unreachable encoding: fall back to IDLE without issuing an ack.
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Per-core completed-grant counters, stepped on the edge that raises ack
  always_ff @(posedge jimmy_clk) begin
    if (reset) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else if (state_r == ST_CAPTURE) begin
      if (gnt_r) begin
        grant_cnt1 <= grant_cnt1 + 8'h01;
      end else begin
        grant_cnt0 <= grant_cnt0 + 8'h01;
      end
    end else begin
      grant_cnt0 <= grant_cnt0;
      grant_cnt1 <= grant_cnt1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for mem_port_arbiter.  Two instances share one clock and reset:
// dut_a with LATENCY=1 and dut_b with LATENCY=3.  A transaction-level model
// (a grant completes LATENCY+1 edges later and returns mem[addr]) predicts
// every output and is compared on each falling edge; directed scenarios add
// hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic jimmy_clk = 1'b0;
  always #5 jimmy_clk = ~jimmy_clk;

  logic       reset;
  logic       req0     [2];
  logic       req1     [2];
  logic [7:0] addr0    [2];
  logic [7:0] addr1    [2];
  logic [7:0] rdata0_o [2];
  logic [7:0] rdata1_o [2];
  logic       ack0_o   [2];
  logic       ack1_o   [2];
  logic [7:0] maddr_o  [2];
  logic [7:0] mdata_v  [2];
  logic       busy_o   [2];
`ifdef ARB_STATS_EN
  logic [7:0] gc0_o    [2];
  logic [7:0] gc1_o    [2];
`endif

  logic [7:0] mem [256];

  assign mdata_v[0] = mem[maddr_o[0]];
  assign mdata_v[1] = mem[maddr_o[1]];

  mem_port_arbiter #(.LATENCY(LAT_A)) dut_a (
    .jimmy_clk  (jimmy_clk),
    .reset      (reset),
    .req0       (req0[0]),
    .addr0      (addr0[0]),
    .rdata0     (rdata0_o[0]),
    .ack0       (ack0_o[0]),
    .req1       (req1[0]),
    .addr1      (addr1[0]),
    .rdata1     (rdata1_o[0]),
    .ack1       (ack1_o[0]),
    .mem_addr   (maddr_o[0]),
    .mem_data   (mdata_v[0]),
`ifdef ARB_STATS_EN
    .grant_cnt0 (gc0_o[0]),
    .grant_cnt1 (gc1_o[0]),
`endif
    .busy       (busy_o[0])
  );

  mem_port_arbiter #(.LATENCY(LAT_B)) dut_b (
    .jimmy_clk  (jimmy_clk),
    .reset      (reset),
    .req0       (req0[1]),
    .addr0      (addr0[1]),
    .rdata0     (rdata0_o[1]),
    .ack0       (ack0_o[1]),
    .req1       (req1[1]),
    .addr1      (addr1[1]),
    .rdata1     (rdata1_o[1]),
    .ack1       (ack1_o[1]),
    .mem_addr   (maddr_o[1]),
    .mem_data   (mdata_v[1]),
`ifdef ARB_STATS_EN
    .grant_cnt0 (gc0_o[1]),
    .grant_cnt1 (gc1_o[1]),
`endif
    .busy       (busy_o[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance
  bit         m_busy [2];
  int         m_rem  [2];
  bit         m_core [2];
  bit         m_last [2];
  bit         m_ack0 [2];
  bit         m_ack1 [2];
  logic [7:0] m_maddr[2];
  logic [7:0] m_rd0  [2];
  logic [7:0] m_rd1  [2];
  logic [7:0] m_cnt0 [2];
  logic [7:0] m_cnt1 [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  // Transaction-level reference: a grant completes LATENCY+1 edges later
  always @(posedge jimmy_clk) begin
    for (int i = 0; i < 2; i++) begin
      m_ack0[i] = 1'b0;
      m_ack1[i] = 1'b0;
      if (reset) begin
        m_busy[i]  = 1'b0;
        m_rem[i]   = 0;
        m_last[i]  = 1'b1;
        m_maddr[i] = 8'h00;
        m_rd0[i]   = 8'h00;
        m_rd1[i]   = 8'h00;
        m_cnt0[i]  = 8'h00;
        m_cnt1[i]  = 8'h00;
      end else if (m_busy[i]) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_busy[i] = 1'b0;
          m_last[i] = m_core[i];
          if (m_core[i]) begin
            m_rd1[i]  = mem[m_maddr[i]];
            m_ack1[i] = 1'b1;
            m_cnt1[i] = m_cnt1[i] + 8'd1;
          end else begin
            m_rd0[i]  = mem[m_maddr[i]];
            m_ack0[i] = 1'b1;
            m_cnt0[i] = m_cnt0[i] + 8'd1;
          end
        end
      end else if (req0[i] || req1[i]) begin
        m_core[i]  = (req0[i] && req1[i]) ? !m_last[i] : (req1[i] == 1'b1);
        m_maddr[i] = m_core[i] ? addr1[i] : addr0[i];
        m_busy[i]  = 1'b1;
        m_rem[i]   = lat_of(i) + 1;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge jimmy_clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk8($sformatf("mem_addr[%0d]", i), maddr_o[i],  m_maddr[i]);
        chk8($sformatf("rdata0[%0d]", i),   rdata0_o[i], m_rd0[i]);
        chk8($sformatf("rdata1[%0d]", i),   rdata1_o[i], m_rd1[i]);
        chk1($sformatf("ack0[%0d]", i),     ack0_o[i],   m_ack0[i]);
        chk1($sformatf("ack1[%0d]", i),     ack1_o[i],   m_ack1[i]);
        chk1($sformatf("busy[%0d]", i),     busy_o[i],   m_busy[i]);
`ifdef ARB_STATS_EN
        chk8($sformatf("grant_cnt0[%0d]", i), gc0_o[i], m_cnt0[i]);
        chk8($sformatf("grant_cnt1[%0d]", i), gc1_o[i], m_cnt1[i]);
`endif
      end
    end
  end

  task automatic step();
    @(posedge jimmy_clk);
    #2;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int t0;
    int t1;
    int n_to;
    int seq[$];

    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 5 + 3);
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h5C;
    mem[8'h30] = 8'hC3;
    mem[8'h40] = 8'h77;
    for (int i = 0; i < 2; i++) begin
      req0[i]  = 1'b0;
      req1[i]  = 1'b0;
      addr0[i] = 8'h00;
      addr1[i] = 8'h00;
    end

    // Reset state
    reset = 1'b1;
    step();
    started = 1'b1;
    step();
    reset = 1'b0;
    chk1("rst_busy",   busy_o[0],   1'b0);
    chk1("rst_ack0",   ack0_o[0],   1'b0);
    chk8("rst_rdata0", rdata0_o[0], 8'h00);
    chk8("rst_maddr",  maddr_o[0],  8'h00);

    // Single request, LATENCY=1
    req0[0]  = 1'b1;
    addr0[0] = 8'h10;
    step();
    chk8("t29_maddr",  maddr_o[0], 8'h10);
    chk1("t29_busy1",  busy_o[0],  1'b1);
    chk1("t29_noack",  ack0_o[0],  1'b0);
    step();
    chk1("t29_busy2",  busy_o[0],  1'b1);
    chk1("t29_early",  ack0_o[0],  1'b0);
    step();
    chk1("t29_ack",    ack0_o[0],   1'b1);
    chk8("t29_rdata",  rdata0_o[0], 8'hA5);
    chk1("t29_idle",   busy_o[0],   1'b0);
    chk1("t29_ack1",   ack1_o[0],   1'b0);
    req0[0] = 1'b0;
    step();
    chk1("t29_pulse",  ack0_o[0],   1'b0);
    chk8("t29_hold_d", rdata0_o[0], 8'hA5);
    chk8("t29_hold_a", maddr_o[0],  8'h10);

    // Simultaneous requests after reset: core 0 first, core 1 three cycles on
    reset_pulse();
    req0[0] = 1'b1; addr0[0] = 8'h01;
    req1[0] = 1'b1; addr1[0] = 8'h02;
    t0 = -1; t1 = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ack0_o[0] && t0 < 0) begin
        t0 = k;
        req0[0] = 1'b0;
      end
      if (ack1_o[0] && t1 < 0) begin
        t1 = k;
        chk8("t30_maddr1", maddr_o[0],  8'h02);
        chk8("t30_rdata1", rdata1_o[0], 8'h22);
        req1[0] = 1'b0;
      end
    end
    chki("t30_ack0_at", t0, 3);
    chki("t30_ack1_at", t1, 6);
    chk8("t30_rdata0",  rdata0_o[0], 8'h11);

    // Both requests held continuously: acks alternate 0,1,0,1
    reset_pulse();
    req0[0] = 1'b1; addr0[0] = 8'h05;
    req1[0] = 1'b1; addr1[0] = 8'h06;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ack0_o[0] && ack1_o[0]) seq.push_back(2);
      else if (ack0_o[0])         seq.push_back(0);
      else if (ack1_o[0])         seq.push_back(1);
    end
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    chki("t31_nacks", seq.size(), 4);
    for (int j = 0; j < 4; j++)
      chki($sformatf("t31_order%0d", j), (j < seq.size()) ? seq[j] : -1, j % 2);
    step();
    step();

    // LATENCY=3: address change during WAIT is ignored
    reset_pulse();
    req0[1] = 1'b1; addr0[1] = 8'h20;
    step();
    chk8("t32_grant_maddr", maddr_o[1], 8'h20);
    addr0[1] = 8'h30;
    t0 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk8("t32_maddr_held", maddr_o[1], 8'h20);
      if (ack0_o[1] && t0 < 0) begin
        t0 = k;
        chk8("t32_rdata", rdata0_o[1], 8'h5C);
        req0[1] = 1'b0;
      end
    end
    chki("t32_latency", t0, 4);

    // Reset during WAIT aborts; request is re-served afterwards
    req0[1] = 1'b1; addr0[1] = 8'h40;
    step();
    chk1("t33_busy", busy_o[1], 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("t33_rst_busy",  busy_o[1],   1'b0);
    chk1("t33_rst_ack",   ack0_o[1],   1'b0);
    chk8("t33_rst_rdata", rdata0_o[1], 8'h00);
    t0 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ack0_o[1] && t0 < 0) begin
        t0 = k;
        chk8("t33_rdata", rdata0_o[1], 8'h77);
        req0[1] = 1'b0;
      end
    end
    chki("t33_reserve", t0, 5);

`ifdef ARB_STATS_EN
    // 257 grants to core 0: counter wraps to 0x01
    reset_pulse();
    chk8("t34_rst_cnt0", gc0_o[0], 8'h00);
    addr0[0] = 8'h10;
    n_to = 0;
    for (int g = 0; g < 257; g++) begin
      req0[0] = 1'b1;
      t0 = -1;
      for (int k = 1; k <= 10 && t0 < 0; k++) begin
        step();
        if (ack0_o[0]) begin
          t0 = k;
          req0[0] = 1'b0;
        end
      end
      if (t0 < 0) n_to = n_to + 1;
    end
    req0[0] = 1'b0;
    chki("t34_timeouts", n_to, 0);
    chk8("t34_cnt0", gc0_o[0], 8'h01);
    chk8("t34_cnt1", gc1_o[0], 8'h00);
`endif

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, memory read latency in jimmy_clk cycles; legal range 1..15.
REQ-002 Port: jimmy_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0  input  1  core 0 read request, level; held until ack0.
REQ-005 Port: addr0  input  8  core 0 read address; stable while req0 is high.
REQ-006 Port: rdata0  output  8  core 0 returned read data, registered.
REQ-007 Port: ack0  output  1  core 0 completion pulse, one cycle wide.
REQ-008 Port: req1 / addr1 / rdata1 / ack1  same widths and meaning as REQ-004..007, for core 1.
REQ-009 Port: mem_addr  output  8  registered address to the shared memory port.
REQ-010 Port: mem_data  input  8  read data from the shared memory port.
REQ-011 Port: busy  output  1  high while a transaction is in progress (WAIT or CAPTURE).
REQ-012 Port: grant_cnt0 / grant_cnt1  output  8 each  completed-grant counters; present only under ARB_STATS_EN.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and CAPTURE.
- IDLE: if any req is high -> WAIT; otherwise stay in IDLE.
- WAIT: after LATENCY cycles -> CAPTURE.
- CAPTURE: one cycle -> IDLE.
REQ-014 In IDLE, with exactly one req high, that core SHALL be granted: mem_addr <= its addr, wait counter <= LATENCY-1, state <= WAIT.
REQ-015 In IDLE, with both reqs high, the core not in last_grant SHALL win (round-robin).
REQ-016 The wait counter SHALL decrement every cycle in WAIT; state SHALL move to CAPTURE on the edge where the counter is 0.
REQ-017 In CAPTURE, on the same edge: rdataX <= mem_data; ackX <= 1; last_grant <= X; state <= IDLE.
REQ-018 ackX SHALL be high for exactly one cycle; the ack of the non-granted core SHALL stay 0.
REQ-019 Latency: ackX and rdataX SHALL become valid LATENCY+1 rising edges after the edge that samples reqX in IDLE.
REQ-020 Throughput: a new grant SHALL be possible on the edge immediately after CAPTURE. Back-to-back period is LATENCY+2 cycles.
REQ-021 A requester SHALL drop req on the cycle ack is seen. A req still high in the IDLE cycle that follows is a new request and is re-arbitrated.
REQ-022 Changes to req/addr during WAIT or CAPTURE SHALL NOT affect the transaction in flight; the address latched in IDLE SHALL be used.
REQ-023 mem_addr and rdataX SHALL hold their last values between transactions.
REQ-024 busy SHALL be 1 in WAIT and CAPTURE and 0 in IDLE.
REQ-025 A core whose req is continuously high SHALL be granted within 2*(LATENCY+2) cycles (starvation bound).

Reset
REQ-026 While reset is high on an edge: state <= IDLE; mem_addr, rdata0, rdata1 <= 0x00; ack0, ack1, busy <= 0; last_grant <= 1, so core 0 wins the first tie.
REQ-027 Reset during WAIT or CAPTURE SHALL abort the transaction with no ack issued. Reset SHALL have priority over every other update.

Configuration
REQ-028 Macro ARB_STATS_EN controls the grant counters.
- Defined: grant_cnt0/grant_cnt1 ports exist, reset to 0x00, increment on each ack of their core, and wrap 0xFF -> 0x00.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Verification
REQ-029 LATENCY=1, mem returns 0xA5 for address 0x10; req0=1, addr0=0x10 in IDLE -> mem_addr=0x10 after 1 edge; ack0=1 and rdata0=0xA5 after 2 edges; busy high for 2 cycles.
REQ-030 After reset, req0 and req1 asserted together (addr0=0x01, addr1=0x02), both held until acked -> core 0 acked first, then core 1 with mem_addr=0x02; acks 3 cycles apart.
REQ-031 Both reqs held high continuously for 12 cycles, LATENCY=1 -> acks alternate 0,1,0,1; no core is acked twice in a row.
REQ-032 LATENCY=3; change addr0 from 0x20 to 0x30 during WAIT -> mem_addr stays 0x20; ack0 4 edges after the grant edge.
REQ-033 Reset asserted in WAIT -> next cycle state is IDLE, ack0=0, rdata0=0x00, busy=0; request re-served after reset drops.
REQ-034 With ARB_STATS_EN defined: 257 grants to core 0 -> grant_cnt0=0x01, grant_cnt1=0x00.
